// File: rtl/router_pkt_tx.sv
// Router write-port packet source: buffers a payload, then streams header+payload+parity
// with pkt_vld held through busy stalls, and samples the router error flag afterwards.
module router_pkt_tx #(
   parameter int ERR_WAIT = 3,
   parameter int GAP      = 1
) (
   input  logic       i_clock,
   input  logic       i_rstn,
   input  logic       i_start,
   input  logic [1:0] i_dest_addr,
   input  logic [5:0] i_pay_len,
   input  logic [7:0] i_pay_data,
   input  logic       i_pay_valid,
   output logic       o_pay_ready,
   output logic [7:0] o_data_in,
   output logic       o_pkt_vld,
   input  logic       i_busy,
   input  logic       i_error,
   output logic       o_tx_idle,
   output logic       o_tx_done,
   output logic       o_tx_err,
   output logic       o_req_reject
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_ERRW, S_GAP
   } state_t;

   state_t     r_state, w_state;
   logic [1:0] r_addr, w_addr;
   logic [5:0] r_len, w_len, r_wr, w_wr, r_rd, w_rd, w_rd_inc;
   logic [7:0] r_par, w_par, r_cnt, w_cnt;
   logic       r_pay_ready, w_pay_ready;
   logic [7:0] r_data, w_data;
   logic       r_vld, w_vld, r_idle, w_idle, r_done, w_done;
   logic       r_err, w_err, r_rej, w_rej;
   logic       w_we, w_xfer;
   logic [7:0] w_hdr;
   logic [7:0] r_buf [64];

   assign w_xfer   = r_pay_ready & i_pay_valid;
   assign w_hdr    = {r_len, r_addr};
   assign w_rd_inc = r_rd + 6'd1;

   always_comb begin
      w_state     = r_state;
      w_addr      = r_addr;
      w_len       = r_len;
      w_wr        = r_wr;
      w_rd        = r_rd;
      w_par       = r_par;
      w_cnt       = r_cnt;
      w_pay_ready = r_pay_ready;
      w_data      = r_data;
      w_vld       = r_vld;
      w_idle      = r_idle;
      w_err       = r_err;
      w_done      = 1'b0;
      w_rej       = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (i_dest_addr == 2'd3 || i_pay_len == 6'd0) begin
                  w_rej = 1'b1;
               end else begin
                  w_state     = S_LOAD;
                  w_addr      = i_dest_addr;
                  w_len       = i_pay_len;
                  w_wr        = 6'd0;
                  w_par       = 8'd0;
                  w_err       = 1'b0;
                  w_pay_ready = 1'b1;
                  w_idle      = 1'b0;
               end
            end
         end
         S_LOAD: begin
            if (w_xfer) begin
               w_we  = 1'b1;
               w_wr  = r_wr + 6'd1;
               w_par = r_par ^ i_pay_data;
               if (r_wr == r_len - 6'd1) begin
                  // Header is folded into the parity as it goes out on the wire.
                  w_state     = S_HEADER;
                  w_pay_ready = 1'b0;
                  w_data      = w_hdr;
                  w_vld       = 1'b1;
                  w_par       = r_par ^ i_pay_data ^ w_hdr;
               end
            end
         end
         S_HEADER: begin
            if (!i_busy) begin
               w_state = S_PAYLOAD;
               w_rd    = 6'd0;
               w_data  = r_buf[0];
            end
         end
         S_PAYLOAD: begin
            if (!i_busy) begin
               if (r_rd == r_len - 6'd1) begin
                  w_state = S_PARITY;
                  w_data  = r_par;
                  w_vld   = 1'b0;
               end else begin
                  w_rd   = w_rd_inc;
                  w_data = r_buf[w_rd_inc];
               end
            end
         end
         S_PARITY: begin
            if (!i_busy) begin
               w_state = S_ERRW;
               w_data  = 8'd0;
               w_cnt   = 8'd0;
            end
         end
         S_ERRW: begin
            w_err = r_err | i_error;
            w_cnt = r_cnt + 8'd1;
            if (r_cnt == 8'(ERR_WAIT - 1)) begin
               w_done = 1'b1;
               w_cnt  = 8'd0;
               if (GAP == 0) begin
                  w_state = S_IDLE;
                  w_idle  = 1'b1;
               end else begin
                  w_state = S_GAP;
               end
            end
         end
         S_GAP: begin
            w_cnt = r_cnt + 8'd1;
            if (r_cnt == 8'(GAP - 1)) begin
               w_state = S_IDLE;
               w_idle  = 1'b1;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state     <= S_IDLE;
         r_addr      <= 2'd0;
         r_len       <= 6'd0;
         r_wr        <= 6'd0;
         r_rd        <= 6'd0;
         r_par       <= 8'd0;
         r_cnt       <= 8'd0;
         r_pay_ready <= 1'b0;
         r_data      <= 8'd0;
         r_vld       <= 1'b0;
         r_idle      <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rej       <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_addr      <= w_addr;
         r_len       <= w_len;
         r_wr        <= w_wr;
         r_rd        <= w_rd;
         r_par       <= w_par;
         r_cnt       <= w_cnt;
         r_pay_ready <= w_pay_ready;
         r_data      <= w_data;
         r_vld       <= w_vld;
         r_idle      <= w_idle;
         r_done      <= w_done;
         r_err       <= w_err;
         r_rej       <= w_rej;
      end
   end

   // Payload store carries no reset; contents are don't-care until written.
   always_ff @(posedge i_clock) begin
      if (w_we) r_buf[r_wr] <= i_pay_data;
   end

   assign o_pay_ready  = r_pay_ready;
   assign o_data_in    = r_data;
   assign o_pkt_vld    = r_vld;
   assign o_tx_idle    = r_idle;
   assign o_tx_done    = r_done;
   assign o_tx_err     = r_err;
   assign o_req_reject = r_rej;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: random payloads/stalls/errors scored against a packet-level model.
module tb_router_pkt_tx;
   localparam int EW = 3;

   logic       clock = 1'b0;
   logic       rstn = 1'b0;
   logic       start = 1'b0;
   logic [1:0] dest_addr = 2'd0;
   logic [5:0] pay_len = 6'd0;
   logic [7:0] pay_data = 8'd0;
   logic       pay_valid = 1'b0;
   logic       pay_ready;
   logic [7:0] data_in;
   logic       pkt_vld;
   logic       busy = 1'b0;
   logic       rtr_err = 1'b0;
   logic       tx_idle, tx_done, tx_err, req_reject;

   int         n_pass = 0;
   int         n_tot  = 0;
   logic [7:0] pay [64];

   router_pkt_tx #(.ERR_WAIT(EW), .GAP(1)) dut (
      .i_clock(clock), .i_rstn(rstn), .i_start(start), .i_dest_addr(dest_addr),
      .i_pay_len(pay_len), .i_pay_data(pay_data), .i_pay_valid(pay_valid),
      .o_pay_ready(pay_ready), .o_data_in(data_in), .o_pkt_vld(pkt_vld),
      .i_busy(busy), .i_error(rtr_err), .o_tx_idle(tx_idle), .o_tx_done(tx_done),
      .o_tx_err(tx_err), .o_req_reject(req_reject)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One packet: the router side accepts a byte whenever busy is low; the model says the
   // accepted stream must be header, payload in order, then the XOR of all of them.
   task automatic run_pkt(input int addr, input int len, input int gap_pct, input int busy_pct,
                          input int err_at, input int stall_idx, input int stall_len);
      logic [7:0] got[$];
      logic [7:0] par_got, exp_par, hdr;
      logic       prev_act, prev_busy, prev_vld, err_at_done, par_cycle, exp_err;
      logic [7:0] prev_data;
      int k, idx, first_hdr, par_k, done_k, phase, stall_cnt, hold_bad, out_bad, extra, pay_bad;
      got.delete();
      par_got = 8'h00; prev_act = 1'b0; prev_busy = 1'b0; prev_vld = 1'b0; prev_data = 8'h00;
      err_at_done = 1'b0; idx = 0; first_hdr = -1; par_k = -1; done_k = -1; phase = 0;
      stall_cnt = 0; hold_bad = 0; out_bad = 0; extra = 0; pay_bad = 0;
      hdr = {6'(len), 2'(addr)};
      exp_err = (err_at >= 1 && err_at <= EW);
      dest_addr = 2'(addr); pay_len = 6'(len); start = 1'b1;
      tick();
      start = 1'b0; k = 1;
      chk("err_clear", {31'd0, tx_err}, 0);
      chk("load_ready", {30'd0, tx_idle, pay_ready}, 2'b01);
      while (k < 3000 && done_k < 0) begin
         if (prev_act && prev_busy && (data_in !== prev_data || pkt_vld !== prev_vld)) hold_bad++;
         if (pkt_vld && phase == 0) begin phase = 1; first_hdr = k; end
         if (pkt_vld && phase == 2) out_bad++;
         if (!pkt_vld && phase != 1 && data_in !== 8'h00) out_bad++;
         par_cycle = (phase == 1) && !pkt_vld;
         if ((pkt_vld || par_cycle) && got.size() == stall_idx && stall_cnt < stall_len) begin
            busy = 1'b1; stall_cnt++;
         end else busy = ($urandom_range(99) < busy_pct);
         if (!busy && pkt_vld) got.push_back(data_in);
         if (!busy && par_cycle) begin par_got = data_in; par_k = k; phase = 2; end
         prev_act = pkt_vld || par_cycle; prev_busy = busy; prev_vld = pkt_vld; prev_data = data_in;
         if (par_k >= 0 && k > par_k && k <= par_k + EW) rtr_err = (k - par_k == err_at);
         else rtr_err = 1'($urandom_range(1));
         if (idx < len) begin
            pay_valid = ($urandom_range(99) >= gap_pct); pay_data = pay[idx];
         end else begin
            pay_valid = 1'($urandom_range(1)); pay_data = 8'($urandom);
         end
         if (pay_valid && pay_ready) begin
            if (idx < len) idx++;
            else extra++;
         end
         tick(); k++;
         if (tx_done) begin done_k = k; err_at_done = tx_err; end
      end
      rtr_err = 1'b0; busy = 1'b0; pay_valid = 1'b0;
      exp_par = hdr;
      for (int i = 0; i < len; i++) exp_par = exp_par ^ pay[i];
      for (int i = 1; i < got.size(); i++) if (i > len || got[i] !== pay[i-1]) pay_bad++;
      chk("done_seen", {31'd0, done_k > 0}, 1);
      chk("tx_err", {31'd0, err_at_done}, {31'd0, exp_err});
      chk("done_lat", done_k - par_k, EW + 1);
      chk("stream_len", got.size(), len + 1);
      chk("header", (got.size() > 0) ? {24'd0, got[0]} : 32'hffff_ffff, {24'd0, hdr});
      chk("payload", pay_bad, 0);
      chk("parity", {24'd0, par_got}, {24'd0, exp_par});
      chk("hold", hold_bad, 0);
      chk("idle_data", out_bad, 0);
      chk("extra_xfer", extra, 0);
      chk("fed", idx, len);
      if (gap_pct == 0) chk("latency", first_hdr, len + 1);
      chk("gap_busy", {31'd0, tx_idle}, 0);
      start = 1'b1; pay_len = 6'd2; dest_addr = 2'd0;
      tick();
      start = 1'b0;
      chk("done_pulse", {31'd0, tx_done}, 0);
      chk("idle_back", {31'd0, tx_idle}, 1);
      chk("err_hold", {31'd0, tx_err}, {31'd0, exp_err});
      tick();
      chk("gap_start_ignored", {30'd0, tx_idle, pay_ready}, 2'b10);
   endtask

   task automatic reject(input logic [1:0] a, input logic [5:0] l);
      dest_addr = a; pay_len = l; start = 1'b1;
      tick();
      start = 1'b0;
      chk("rej_pulse", {29'd0, req_reject, tx_idle, pay_ready}, 3'b110);
      tick();
      chk("rej_after", {29'd0, req_reject, tx_idle, pay_ready}, 3'b010);
   endtask

   initial begin
      int a, l, w;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_data", {24'd0, data_in}, 0);
      chk("rst_vld_ready", {30'd0, pkt_vld, pay_ready}, 0);
      chk("rst_flags", {28'd0, tx_done, tx_err, req_reject, tx_idle}, 4'b0001);
      #2 rstn = 1'b1;
      tick();

      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
      run_pkt(1, 4, 0, 0, -1, -1, 0);
      run_pkt(1, 4, 0, 0, -1, 2, 3);

      reject(2'd3, 6'd5);
      reject(2'd1, 6'd0);

      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_pkt(0, 5, 0, 0, 2, -1, 0);
      run_pkt(2, 63, 40, 20, -1, -1, 0);

      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
         a = int'($urandom_range(2));
         l = (p == 0) ? 1 : int'($urandom_range(63, 1));
         run_pkt(a, l, 30, 25, int'($urandom_range(EW)), -1, 0);
      end

      dest_addr = 2'd2; pay_len = 6'd8; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin pay_valid = 1'b1; pay_data = 8'(i + 1); tick(); end
      pay_valid = 1'b0; busy = 1'b0; w = 0;
      while (!pkt_vld && w < 20) begin tick(); w++; end
      chk("rst_hdr_seen", {31'd0, pkt_vld}, 1);
      tick(); tick();
      #2 rstn = 1'b0;
      #1;
      chk("midrst_vld", {31'd0, pkt_vld}, 0);
      chk("midrst_idle", {31'd0, tx_idle}, 1);
      chk("midrst_data", {24'd0, data_in}, 0);
      #3 rstn = 1'b1;
      tick();
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      run_pkt(0, 7, 0, 10, 3, -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
